countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Sequencing controller that sits directly upstream of the 4-bit down counter and drives its `IN`, `Latch` and `dec` inputs while watching its `zero` flag. It accepts a start request with a 4-bit count value, loads the counter, issues one decrement every `TICK_DIV` cycles, and reports completion with a one-cycle `done` pulse. It also initialises the counter after reset, because the counter itself has no reset, and it supports abort.

## Interface
- `TICK_DIV`, default 4: cycles per decrement in RUN; legal range 1..16. The prescaler is `$clog2(TICK_DIV)` bits wide, minimum 1 bit.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: start request; sampled only in IDLE.
- `load_val` input 4: count value; captured on an accepted `start`.
- `abort` input 1: cancel; honoured in LOAD, ARM and RUN.
- `zero` input 1: counter zero flag (combinational from the counter's registered count).
- `cnt_in` output 4: drives the counter's `IN`.
- `latch` output 1: drives the counter's `Latch`.
- `dec` output 1: drives the counter's `dec`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- All outputs are decoded from the state register, the captured value register `val_q` and the prescaler `presc`. The only exception is `dec`, which is additionally gated by `zero`.
- States:
  - INIT: `latch`=1, `cnt_in`=0, `busy`=1. Lasts one cycle, then goes to IDLE.
  - IDLE: `busy`=0. If `start`=1, capture `val_q`<=`load_val` and go to LOAD. `abort` is ignored in IDLE. When `start` and `abort` are both high in IDLE, the start is accepted.
  - LOAD: `latch`=1, `cnt_in`=`val_q`. The counter loads on this cycle's closing edge. Next state is ARM.
  - ARM: settle cycle in which `zero` now reflects `val_q`. If `zero`=1, go to DONE. Otherwise go to RUN with `presc`<=0.
  - RUN: `presc` increments each cycle and wraps from `TICK_DIV`-1 to 0.
    - `dec`=1 exactly when `presc`==`TICK_DIV`-1 and `zero`=0.
    - If `zero`=1, go to DONE; `dec` is 0 in that cycle.
  - DONE: `done`=1 and `busy`=1 for one cycle, then go to IDLE.
- Abort: `abort`=1 in LOAD, ARM or RUN goes to INIT next cycle, which zeroes the counter, and then to IDLE. No `done` pulse is issued for an aborted run. `abort` in INIT or DONE is ignored.
- `start` while `busy`=1 is dropped, not queued.
- In every state other than the ones listed, `latch`=0, `dec`=0 and `cnt_in`=`val_q`.
- Reset:
  - `rst`=1 at an edge forces INIT and clears `val_q` and `presc` to 0. The next-state logic is overridden.
  - While `rst` is held, the block stays in INIT, so the counter reloads 0 every cycle.
  - Output values while in reset / INIT: `latch`=1, `cnt_in`=0, `dec`=0, `busy`=1, `done`=0.
- Reset mid-run behaves identically to reset at power-up; no `done` pulse is issued.

## Timing
- Cycle numbering: E0 is the edge at which `start` is sampled high in IDLE, and cN is the N-th cycle after E0.
- `load_val`=N≥1:
  - c1 is LOAD and c2 is ARM; RUN begins at c3 with `presc`=0.
  - `dec` pulses at c(2+k·`TICK_DIV`) for k=1..N.
  - `zero` rises at c(3+N·`TICK_DIV`), `done`=1 at c(4+N·`TICK_DIV`), and the block is back in IDLE at c(5+N·`TICK_DIV`).
- `load_val`=0: LOAD c1, ARM c2, `done`=1 at c3, IDLE at c4. No `dec` is issued.
- Back-to-back operation: `start` is accepted again at the first IDLE cycle after DONE.
- After reset deassertion: INIT for one cycle, then IDLE, so `busy` falls one cycle after `rst` falls.

## Test plan
- Reset, then release: `latch`=1 and `cnt_in`=0 during reset and INIT; `busy`=0 one cycle after `rst` falls; the counter's `zero`=1.
- `TICK_DIV`=4, `start` with `load_val`=3: `dec` at c6, c10 and c14 only; `done` high only at c16; IDLE at c17.
- `load_val`=0: no `dec`; `done` at c3.
- `TICK_DIV`=1, `load_val`=15: `dec` high on every cycle c3..c17; `done` at c19.
- `abort` at c8 of a `load_val`=5 run: INIT at c9 with `latch`=1 and `cnt_in`=0; IDLE at c10; `done` never asserted; counter `zero`=1.
- `start` pulses during RUN are ignored. `rst` asserted mid-RUN returns the block to INIT on the next edge with no `done`. `start` and `abort` together in IDLE start a run.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Sequencing controller for a resetless 4-bit down counter: initialises it, loads a
// start value, paces decrements with a prescaler and pulses done when it reaches zero.
module countdown_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] load_val,
  input  logic       abort,
  input  logic       zero,
  output logic [3:0] cnt_in,
  output logic       latch,
  output logic       dec,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [3:0]     val_reg, val_next;
  logic [PW-1:0]  presc_reg, presc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_INIT;
      val_reg   <= '0;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      val_reg   <= val_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    val_next   = val_reg;
    presc_next = presc_reg;
    cnt_in     = val_reg;
    latch      = 1'b0;
    dec        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_reg)
      S_INIT: begin
        // Counter has no reset of its own, so force it to zero here.
        latch      = 1'b1;
        cnt_in     = 4'd0;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          val_next   = load_val;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        latch      = 1'b1;
        state_next = abort ? S_INIT : S_ARM;
      end
      S_ARM: begin
        if (abort) begin
          state_next = S_INIT;
        end else if (zero) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RUN;
          presc_next = '0;
        end
      end
      S_RUN: begin
        presc_next = (presc_reg == PRESC_MAX) ? '0 : presc_reg + PW'(1);
        dec        = (presc_reg == PRESC_MAX) && !zero;
        if (abort) begin
          state_next = S_INIT;
        end else if (zero) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: two instances (TICK_DIV 4 and 1), each driving a behavioural
// counter; expected dec/done cycles are queued at start and popped as pulses appear.
module tb_countdown_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start4 = 1'b0, abort4 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] load4 = 4'd0, load1 = 4'd0;
  logic       zero4, latch4, dec4, busy4, done4;
  logic       zero1, latch1, dec1, busy1, done1;
  logic [3:0] cnt_in4, cnt_in1;
  logic [3:0] count4, count1;

  countdown_ctrl #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .load_val(load4), .abort(abort4),
    .zero(zero4), .cnt_in(cnt_in4), .latch(latch4), .dec(dec4), .busy(busy4), .done(done4)
  );

  countdown_ctrl #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .load_val(load1), .abort(abort1),
    .zero(zero1), .cnt_in(cnt_in1), .latch(latch1), .dec(dec1), .busy(busy1), .done(done1)
  );

  // Downstream 4-bit down counter: no reset, Latch has priority over dec.
  always @(posedge clk) begin
    if (latch4) count4 <= cnt_in4;
    else if (dec4) count4 <= count4 - 4'd1;
    if (latch1) count1 <= cnt_in1;
    else if (dec1) count1 <= count1 - 4'd1;
  end
  assign zero4 = (count4 == 4'd0);
  assign zero1 = (count1 == 4'd0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int base     = 0;
  int q_dec4[$], q_done4[$], q_dec1[$], q_done1[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard side: every observed pulse must match the head of its queue.
  always @(negedge clk) begin
    if (dec4 === 1'b1) begin
      if (q_dec4.size() == 0) chk("dec4_unexpected", cyc - base, -1);
      else chk("dec4_cycle", cyc - base, q_dec4.pop_front() - base);
    end
    if (done4 === 1'b1) begin
      if (q_done4.size() == 0) chk("done4_unexpected", cyc - base, -1);
      else chk("done4_cycle", cyc - base, q_done4.pop_front() - base);
    end
    if (dec1 === 1'b1) begin
      if (q_dec1.size() == 0) chk("dec1_unexpected", cyc - base, -1);
      else chk("dec1_cycle", cyc - base, q_dec1.pop_front() - base);
    end
    if (done1 === 1'b1) begin
      if (q_done1.size() == 0) chk("done1_unexpected", cyc - base, -1);
      else chk("done1_cycle", cyc - base, q_done1.pop_front() - base);
    end
  end

  // Called at a negedge while the target is IDLE; the next posedge is E0, so cN is cyc==base+N.
  task automatic start_op(input int id, input logic [3:0] v, input logic ab,
                          input int max_dec, input bit exp_done);
    int td;
    int n;
    td   = (id == 0) ? 4 : 1;
    n    = int'(v);
    base = cyc;
    if (id == 0) begin start4 = 1'b1; load4 = v; abort4 = ab; end
    else         begin start1 = 1'b1; load1 = v; abort1 = ab; end
    for (int k = 1; k <= n && k <= max_dec; k++) begin
      if (id == 0) q_dec4.push_back(base + 2 + k * td);
      else         q_dec1.push_back(base + 2 + k * td);
    end
    if (exp_done) begin
      if (id == 0) q_done4.push_back((n == 0) ? base + 3 : base + 4 + n * td);
      else         q_done1.push_back((n == 0) ? base + 3 : base + 4 + n * td);
    end
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic wait_idle(input int id, input int exp_rel);
    int budget;
    budget = 200;
    while (((id == 0) ? busy4 : busy1) !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("idle_timeout", 0, 1);
    else chk((id == 0) ? "idle4_cycle" : "idle1_cycle", cyc - base, exp_rel);
  endtask

  initial begin
    // Reset held for several cycles: INIT outputs, counter reloaded with 0.
    repeat (3) @(negedge clk);
    chk("rst_latch", int'(latch4), 1);
    chk("rst_cnt_in", int'(cnt_in4), 0);
    chk("rst_busy", int'(busy4), 1);
    chk("rst_dec", int'(dec4), 0);
    chk("rst_done", int'(done4), 0);
    rst = 1'b0;
    chk("init_latch", int'(latch4), 1);
    @(negedge clk);
    chk("post_rst_busy4", int'(busy4), 0);
    chk("post_rst_busy1", int'(busy1), 0);
    chk("post_rst_zero4", int'(zero4), 1);
    chk("post_rst_latch", int'(latch4), 0);

    // load 3 at TICK_DIV 4, with a stray start during RUN.
    start_op(0, 4'd3, 1'b0, 15, 1'b1);
    wait_rel(8);
    start4 = 1'b1; load4 = 4'd9;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle(0, 17);
    chk("ignored_start_val", int'(cnt_in4), 3);

    // load 0, then back-to-back load 1 in the first IDLE cycle.
    start_op(0, 4'd0, 1'b0, 15, 1'b1);
    wait_idle(0, 4);
    start_op(0, 4'd1, 1'b0, 15, 1'b1);
    wait_idle(0, 9);

    // TICK_DIV 1, load 15: dec every cycle c3..c17.
    start_op(1, 4'd15, 1'b0, 15, 1'b1);
    wait_idle(1, 20);
    chk("td1_zero", int'(zero1), 1);

    // Abort at c8 of a load 5 run: only the c6 dec, no done.
    start_op(0, 4'd5, 1'b0, 1, 1'b0);
    wait_rel(8);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("abort_init_latch", int'(latch4), 1);
    chk("abort_init_cnt_in", int'(cnt_in4), 0);
    chk("abort_init_busy", int'(busy4), 1);
    @(negedge clk);
    chk("abort_idle_busy", int'(busy4), 0);
    chk("abort_idle_rel", cyc - base, 10);
    chk("abort_zero", int'(zero4), 1);

    // start and abort together in IDLE: run proceeds.
    start_op(0, 4'd2, 1'b1, 15, 1'b1);
    wait_idle(0, 13);

    // Reset mid-RUN: INIT on the next edge, no done.
    start_op(0, 4'd5, 1'b0, 1, 1'b0);
    wait_rel(7);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_latch", int'(latch4), 1);
    chk("midrst_cnt_in", int'(cnt_in4), 0);
    chk("midrst_busy", int'(busy4), 1);
    chk("midrst_dec", int'(dec4), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", int'(busy4), 0);
    chk("midrst_zero", int'(zero4), 1);
    repeat (4) @(negedge clk);

    chk("dec4_left", q_dec4.size(), 0);
    chk("done4_left", q_done4.size(), 0);
    chk("dec1_left", q_dec1.size(), 0);
    chk("done1_left", q_done1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
